stream_rr_arbiter: RTL and testbench

//  Shares one downstream valid/ready stream among NUM_PORTS upstream requesters.

---
 rtl/stream_arb_pkg.sv | 39 +++
 rtl/stream_rr_arbiter_if.sv | 33 +++
 rtl/rr_priority_pick.sv | 29 ++
 rtl/stream_rr_arbiter.sv | 131 +++++++++++++
 tb/tb_stream_rr_arbiter.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/stream_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module : stream_arb_pkg
// Brief  : Shared state encoding and round-robin pick helper for the arbiter.
// Rev    : 1.0  initial release
// ============================================================================
package stream_arb_pkg;

    localparam int unsigned MAX_PORTS = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_GRANT = 2'b01,
        ST_HALT  = 2'b11
    } state_t;

    // Index of the first set bit of req at or after ptr, wrapping at n.
    function automatic logic [3:0] rr_pick(
        input logic [MAX_PORTS-1:0] req,
        input logic [3:0]           ptr,
        input int unsigned          n
    );
        logic [3:0] r;
        logic       found;
        r     = 4'd0;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_PORTS; i++) begin
            int unsigned k;
            k = (32'(ptr) + i) % n;
            if ((i < n) && !found && req[k[3:0]]) begin
                r     = k[3:0];
                found = 1'b1;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stream_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : stream_rr_arbiter_if
// Brief  : Upstream/downstream stream bundle of the round-robin arbiter.
// Rev    : 1.0  initial release
// ============================================================================
interface stream_rr_arbiter_if #(
    parameter int NUM_PORTS = 4,
    parameter int WIDTH     = 16
);
    localparam int SRC_W = $clog2(NUM_PORTS);

    logic [NUM_PORTS*WIDTH-1:0] i_in_data;
    logic [NUM_PORTS-1:0]       i_in_valid;
    logic [NUM_PORTS-1:0]       i_in_last;
    logic [NUM_PORTS-1:0]       o_in_ready;
    logic [WIDTH-1:0]           o_out_data;
    logic                       o_out_last;
    logic [SRC_W-1:0]           o_out_src;
    logic                       o_out_valid;
    logic                       i_out_ready;

    modport slave (
        input  i_in_data, i_in_valid, i_in_last, i_out_ready,
        output o_in_ready, o_out_data, o_out_last, o_out_src, o_out_valid
    );

    modport master (
        output i_in_data, i_in_valid, i_in_last, i_out_ready,
        input  o_in_ready, o_out_data, o_out_last, o_out_src, o_out_valid
    );
endinterface
`default_nettype wire

// File: rtl/rr_priority_pick.sv
`default_nettype none
// ============================================================================
// Module : rr_priority_pick
// Brief  : Combinational cyclic priority picker starting at a pointer.
// Rev    : 1.0  initial release
// ============================================================================
module rr_priority_pick
    import stream_arb_pkg::*;
#(
    parameter int NUM_PORTS = 4
) (
    input  logic [NUM_PORTS-1:0]         i_req,
    input  logic [$clog2(NUM_PORTS)-1:0] i_ptr,
    output logic [$clog2(NUM_PORTS)-1:0] o_idx,
    output logic                         o_any
);
    localparam int SRC_W = $clog2(NUM_PORTS);

    logic [MAX_PORTS-1:0] w_req_ext;
    logic [3:0]           w_ptr_ext;
    logic [3:0]           w_pick;

    assign w_req_ext = MAX_PORTS'(i_req);
    assign w_ptr_ext = 4'(i_ptr);
    assign w_pick    = rr_pick(w_req_ext, w_ptr_ext, NUM_PORTS);
    assign o_idx     = SRC_W'(w_pick);
    assign o_any     = |i_req;
endmodule
`default_nettype wire

// File: rtl/stream_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : stream_rr_arbiter
// Brief  : Packet-locked round-robin stream arbiter with registered skid output.
// Rev    : 1.0  initial release
// ============================================================================
module stream_rr_arbiter
    import stream_arb_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int WIDTH     = 16
) (
    input  wire logic           i_clock,
    input  wire logic           i_reset,
    stream_rr_arbiter_if.slave  bus
);
    localparam int SRC_W = $clog2(NUM_PORTS);

    state_t             r_state, w_state_nxt;
    logic [SRC_W-1:0]   r_grant, w_grant_nxt;
    logic [SRC_W-1:0]   r_rr_ptr, w_rr_ptr_nxt;
    logic [SRC_W-1:0]   w_pick_idx;
    logic               w_pick_any;

    logic               r_main_valid, r_main_last, r_skid_full, r_skid_last;
    logic [WIDTH-1:0]   r_main_data, r_skid_data;
    logic [SRC_W-1:0]   r_main_src, r_skid_src;

    logic [NUM_PORTS-1:0] w_in_ready;
    logic [WIDTH-1:0]     w_beat_data;
    logic                 w_beat_last, w_in_fire, w_out_fire;

    rr_priority_pick #(.NUM_PORTS(NUM_PORTS)) u_pick (
        .i_req (bus.i_in_valid),
        .i_ptr (r_rr_ptr),
        .o_idx (w_pick_idx),
        .o_any (w_pick_any)
    );

    assign w_beat_data = bus.i_in_data[int'(r_grant)*WIDTH +: WIDTH];
    assign w_beat_last = bus.i_in_last[r_grant];
    assign w_in_fire   = (r_state == ST_GRANT) && !r_skid_full && bus.i_in_valid[r_grant];
    assign w_out_fire  = r_main_valid && bus.i_out_ready;

    // Ready comes from registers only, so downstream ready never reaches upstream combinationally.
    always_comb begin
        w_in_ready = '0;
        if ((r_state == ST_GRANT) && !r_skid_full) begin
            w_in_ready[r_grant] = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_rr_ptr_nxt = r_rr_ptr;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_any) begin
                    w_grant_nxt = w_pick_idx;
                    w_state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (w_in_fire && w_beat_last) begin
                    w_rr_ptr_nxt = (r_grant == SRC_W'(NUM_PORTS-1)) ? '0 : r_grant + 1'b1;
                    w_state_nxt  = ST_IDLE;
                end
            end
            ST_HALT: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state  <= ST_IDLE;
            r_grant  <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
        end
    end

    // Main holds the presented beat; skid catches the one beat accepted while main is stalled.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_main_valid <= 1'b0;
            r_main_data  <= '0;
            r_main_last  <= 1'b0;
            r_main_src   <= '0;
            r_skid_full  <= 1'b0;
            r_skid_data  <= '0;
            r_skid_last  <= 1'b0;
            r_skid_src   <= '0;
        end else begin
            if (w_out_fire) begin
                if (r_skid_full) begin
                    r_main_data <= r_skid_data;
                    r_main_last <= r_skid_last;
                    r_main_src  <= r_skid_src;
                    r_skid_full <= 1'b0;
                end else begin
                    r_main_valid <= 1'b0;
                end
            end
            if (w_in_fire) begin
                if (!r_main_valid || w_out_fire) begin
                    r_main_valid <= 1'b1;
                    r_main_data  <= w_beat_data;
                    r_main_last  <= w_beat_last;
                    r_main_src   <= r_grant;
                end else begin
                    r_skid_full <= 1'b1;
                    r_skid_data <= w_beat_data;
                    r_skid_last <= w_beat_last;
                    r_skid_src  <= r_grant;
                end
            end
        end
    end

    assign bus.o_in_ready  = w_in_ready;
    assign bus.o_out_valid = r_main_valid;
    assign bus.o_out_data  = r_main_data;
    assign bus.o_out_last  = r_main_last;
    assign bus.o_out_src   = r_main_src;
endmodule
`default_nettype wire

// File: tb/tb_stream_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_stream_rr_arbiter
// Brief  : Scoreboard bench for stream_rr_arbiter with a packet-level RR model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_stream_rr_arbiter;
    localparam int NP = 4;
    localparam int W  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    stream_rr_arbiter_if #(.NUM_PORTS(NP), .WIDTH(W)) bus ();

    stream_rr_arbiter #(.NUM_PORTS(NP), .WIDTH(W)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    typedef struct packed { logic first; logic last; logic [W-1:0] data; } beat_t;
    typedef struct packed { logic [1:0] src; logic last; logic [W-1:0] data; } obeat_t;

    beat_t  pq[NP][$];
    obeat_t exp_q[$];
    int     checks = 0;
    int     errors = 0;
    int     model_ptr = 0;
    bit     drv_en = 1'b0;
    bit     gaps = 1'b0;
    int     rdy_mode = 0;
    int     rdy_cnt = 0;
    int     cyc = 0;
    int     occ = 0;
    int     fire_cyc[$];
    logic [NP-1:0] in_fire_cap;
    bit     prev_stall = 1'b0;
    obeat_t prev_beat;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Upstream drivers: the first beat of a pending packet is always offered, so the
    // requesting set at every arbitration is exactly the set of ports with work left.
    always @(negedge clk) in_fire_cap = bus.i_in_valid & bus.o_in_ready;

    always @(posedge clk) begin
        #1;
        for (int k = 0; k < NP; k++) begin
            if (in_fire_cap[k] && pq[k].size() > 0) void'(pq[k].pop_front());
            if (drv_en && pq[k].size() > 0) begin
                bus.i_in_data[k*W +: W] = pq[k][0].data;
                bus.i_in_last[k]        = pq[k][0].last;
                bus.i_in_valid[k]       = pq[k][0].first || !gaps || ($urandom_range(0, 3) != 0);
            end else begin
                bus.i_in_data[k*W +: W] = W'($urandom);
                bus.i_in_last[k]        = 1'($urandom);
                bus.i_in_valid[k]       = 1'b0;
            end
        end
        case (rdy_mode)
            0:       bus.i_out_ready = 1'b1;
            1:       bus.i_out_ready = ((rdy_cnt % 4) == 0) || ((rdy_cnt % 4) == 3);
            default: bus.i_out_ready = ($urandom_range(0, 2) != 0);
        endcase
        rdy_cnt++;
    end

    // Monitor: occupancy-based output checks plus in-order scoreboard popping.
    always @(negedge clk) begin
        obeat_t cur;
        cyc++;
        cur = {bus.o_out_src, bus.o_out_last, bus.o_out_data};
        if (rst) begin
            occ        = 0;
            prev_stall = 1'b0;
        end else begin
            check("ready_onehot0", 32'($onehot0(bus.o_in_ready)), 32'd1);
            check("valid_vs_occupancy", 32'(bus.o_out_valid), 32'(occ > 0));
            if (occ >= 2) check("ready_when_skid_full", 32'(bus.o_in_ready), 32'd0);
            if (prev_stall) check("hold_while_stalled", 32'(cur), 32'(prev_beat));
            if (bus.o_out_valid && bus.i_out_ready) begin
                fire_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat actual=%0h required=none", cur);
                end else begin
                    check("out_beat", 32'(cur), 32'(exp_q.pop_front()));
                end
                occ--;
            end
            if (|(bus.i_in_valid & bus.o_in_ready)) occ++;
            prev_stall = bus.o_out_valid && !bus.i_out_ready;
            prev_beat  = cur;
        end
    end

    task automatic load(input int port, input int nbeats, input logic [W-1:0] base, input bit rnd);
        for (int i = 0; i < nbeats; i++) begin
            beat_t b;
            b.first = (i == 0);
            b.last  = (i == nbeats - 1);
            b.data  = rnd ? W'($urandom) : base + W'(i);
            pq[port].push_back(b);
        end
    endtask

    // Reference: whole packets served round-robin among ports that still hold packets.
    task automatic build_expected();
        beat_t m[NP][$];
        for (int k = 0; k < NP; k++) m[k] = pq[k];
        forever begin
            int sel = -1;
            for (int i = 0; i < NP; i++) begin
                int k = (model_ptr + i) % NP;
                if (sel < 0 && m[k].size() > 0) sel = k;
            end
            if (sel < 0) break;
            forever begin
                beat_t b = m[sel].pop_front();
                exp_q.push_back({2'(sel), b.last, b.data});
                if (b.last) break;
            end
            model_ptr = (sel + 1) % NP;
        end
    endtask

    task automatic wait_done(input string name);
        int pend;
        for (int i = 0; i < 4000; i++) begin
            pend = exp_q.size();
            for (int k = 0; k < NP; k++) pend += pq[k].size();
            if (pend == 0) break;
            @(negedge clk);
        end
        if (pend != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=%0d pending required=0", name, pend);
            exp_q.delete();
            for (int k = 0; k < NP; k++) pq[k].delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int gapv[$];
        repeat (3) @(negedge clk);
        check("rst_out_valid", 32'(bus.o_out_valid), 32'd0);
        check("rst_in_ready", 32'(bus.o_in_ready), 32'd0);
        check("rst_out_data", 32'(bus.o_out_data), 32'd0);
        check("rst_out_last", 32'(bus.o_out_last), 32'd0);
        check("rst_out_src", 32'(bus.o_out_src), 32'd0);
        rst    = 1'b0;
        drv_en = 1'b1;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_in_ready", 32'(bus.o_in_ready), 32'd0);
            check("idle_out_valid", 32'(bus.o_out_valid), 32'd0);
        end

        // All four ports, 2-beat packets, free-flowing output.
        for (int k = 0; k < NP; k++) load(k, 2, W'(k * 16), 1'b0);
        build_expected();
        fire_cyc.delete();
        wait_done("all_ports");
        gapv = '{1, 2, 1, 2, 1, 2, 1};
        check("all_ports_beats", 32'(fire_cyc.size()), 32'd8);
        for (int i = 1; i < fire_cyc.size() && i < 8; i++)
            check("all_ports_spacing", 32'(fire_cyc[i] - fire_cyc[i-1]), 32'(gapv[i-1]));

        // Long packet under a 1,0,0,1 downstream ready pattern.
        rdy_mode = 1;
        load(2, 8, 16'h2000, 1'b0);
        build_expected();
        wait_done("stall_pattern");

        // Pointer now at 3: port 3 must win over port 1.
        rdy_mode = 0;
        load(1, 2, 16'h0010, 1'b0);
        load(3, 2, 16'h0030, 1'b0);
        build_expected();
        wait_done("ptr3");

        // Reset on the third beat of a 5-beat packet.
        load(0, 5, 16'h0500, 1'b0);
        build_expected();
        for (int i = 0; i < 200 && pq[0].size() > 3; i++) @(negedge clk);
        rst    = 1'b1;
        drv_en = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 32'(bus.o_out_valid), 32'd0);
        check("midrst_in_ready", 32'(bus.o_in_ready), 32'd0);
        check("midrst_out_data", 32'(bus.o_out_data), 32'd0);
        check("midrst_out_last", 32'(bus.o_out_last), 32'd0);
        check("midrst_out_src", 32'(bus.o_out_src), 32'd0);
        for (int k = 0; k < NP; k++) pq[k].delete();
        exp_q.delete();
        model_ptr = 0;
        load(0, 2, 16'h0600, 1'b0);
        build_expected();
        rst    = 1'b0;
        drv_en = 1'b1;
        @(negedge clk);
        check("postrst_cycle1_ready", 32'(bus.o_in_ready), 32'd0);
        @(negedge clk);
        check("postrst_grant_port0", 32'(bus.o_in_ready), 32'b0001);
        wait_done("postrst");

        // Back-to-back single-beat packets from port 1.
        for (int i = 0; i < 6; i++) load(1, 1, W'(16'h0100 + i), 1'b0);
        build_expected();
        fire_cyc.delete();
        wait_done("single_beat");
        check("single_beat_count", 32'(fire_cyc.size()), 32'd6);
        for (int i = 1; i < fire_cyc.size(); i++)
            check("single_beat_spacing", 32'(fire_cyc[i] - fire_cyc[i-1]), 32'd2);

        // Randomized packets, mid-packet valid gaps and random backpressure.
        rdy_mode = 2;
        gaps     = 1'b1;
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < NP; k++) begin
                int npk = $urandom_range(0, 2);
                for (int p = 0; p < npk; p++) load(k, $urandom_range(1, 5), '0, 1'b1);
            end
            build_expected();
            wait_done("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
